// File: rtl/rgb_fader_pkg.sv
// rgb_fader_pkg: shared definitions for the RGB fader.
//   - fader FSM state encoding
//   - default intensity width and fade prescaler width
//   - channel count (red, green, blue)
package rgb_fader_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DIV_BITS = 16;
  localparam int NUM_CH       = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

endpackage

// File: rtl/rgb_fader_channel.sv
// rgb_fade_channel: one colour channel of the fader.
//   Holds the current and target intensity, steps current one LSB toward
//   target on each step strobe, and drives a PWM bit by comparing the shared
//   PWM counter against the channel duty.
//   Optional feature macro: RGB_FADER_GAMMA_EN (duty = cur^2 >> P_WIDTH).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load        latch tgt_in as the new target
//   step        fade tick: move current one LSB toward target
//   tgt_in      new target intensity
//   pwm_cnt     shared free-running PWM counter
//   at_tgt      current == target
//   led         registered PWM output, active-high
module rgb_fade_channel
  import rgb_fader_pkg::*;
#(
  parameter int P_WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [P_WIDTH-1:0] tgt_in,
  input  logic [P_WIDTH-1:0] pwm_cnt,
  output logic               at_tgt,
  output logic               led
);

  logic [P_WIDTH-1:0] cur;
  logic [P_WIDTH-1:0] tgt;
  logic [P_WIDTH-1:0] duty;

`ifdef RGB_FADER_GAMMA_EN
  // Square-law duty for perceptual dimming; keep the top half of the product.
  logic [2*P_WIDTH-1:0] sq;
  assign sq   = {{P_WIDTH{1'b0}}, cur} * {{P_WIDTH{1'b0}}, cur};
  assign duty = sq[2*P_WIDTH-1:P_WIDTH];
`else
  assign duty = cur;
`endif

  assign at_tgt = (cur == tgt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur <= '0;
      tgt <= '0;
      led <= 1'b0;
    end else begin
      if (load) tgt <= tgt_in;
      // Strict compares: equal means hold, so no overshoot and no wrap.
      if (step) begin
        if (cur < tgt)      cur <= cur + 1'b1;
        else if (cur > tgt) cur <= cur - 1'b1;
      end
      // Compare uses the counter value of this cycle, so the pin lags it by one.
      led <= (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/rgb_fader.sv
// rgb_fader: accepts RGB target intensities over valid/ready and ramps each
// channel toward its target one LSB per fade tick, driving PWM LED pins.
//   Optional feature macro: RGB_FADER_GAMMA_EN (square-law duty in channels).
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_valid, o_ready   target handshake (accepted only in IDLE)
//   i_r, i_g, i_b      target intensities
//   o_done             one-cycle pulse when a fade completes
//   o_led_r/g/b        PWM outputs, active-high
module rgb_fader
  import rgb_fader_pkg::*;
#(
  parameter int P_WIDTH    = DEF_WIDTH,
  parameter int P_DIV_BITS = DEF_DIV_BITS
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [P_WIDTH-1:0] i_r,
  input  logic [P_WIDTH-1:0] i_g,
  input  logic [P_WIDTH-1:0] i_b,
  output logic               o_done,
  output logic               o_led_r,
  output logic               o_led_g,
  output logic               o_led_b
);

  state_t                          state, state_nxt;
  logic [P_DIV_BITS-1:0]           presc;
  logic [P_WIDTH-1:0]              pwm_cnt;
  logic [NUM_CH-1:0][P_WIDTH-1:0]  tgt_in;
  logic [NUM_CH-1:0]               at_tgt;
  logic [NUM_CH-1:0]               led;
  logic                            accept, tick, step, all_at;
  logic                            ready_nxt, done_nxt;

  // Lane 0 = red, 1 = green, 2 = blue.
  assign tgt_in = {i_b, i_g, i_r};
  assign accept = i_valid && o_ready && (state == IDLE);
  assign tick   = &presc;
  assign step   = tick && (state == FADE);
  assign all_at = &at_tgt;

  // o_ready and o_done are registered copies of the next-state decision, so
  // o_ready rises on the first edge out of reset and drops the cycle after accept.
  always_comb begin
    state_nxt = state;
    ready_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = FADE;
        else        ready_nxt = 1'b1;
      end
      FADE: begin
        if (all_at) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_ready <= 1'b0;
      o_done  <= 1'b0;
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      state   <= state_nxt;
      o_ready <= ready_nxt;
      o_done  <= done_nxt;
      presc   <= presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rgb_fade_channel #(.P_WIDTH(P_WIDTH)) u_ch (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .load    (accept),
      .step    (step),
      .tgt_in  (tgt_in[c]),
      .pwm_cnt (pwm_cnt),
      .at_tgt  (at_tgt[c]),
      .led     (led[c])
    );
  end

  assign o_led_r = led[0];
  assign o_led_g = led[1];
  assign o_led_b = led[2];

endmodule
